// File: rtl/dac_stream_feeder.sv
// dac_stream_feeder: paces 12-bit samples from a producer FIFO into the
// TLV5616 DAC driver using a level-held new_val/complete handshake.
// Optional build macro DAC_FEEDER_HOLD_EN: when defined, a rate tick that
// finds the FIFO empty re-sends the last sample (zero-order hold); when not
// defined, such a tick produces no transfer. Underruns are counted in both.
module dac_stream_feeder #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         rate_div,
  input  logic                     s_valid,
  input  logic [11:0]              s_data,
  output logic                     s_ready,
  output logic                     dac_new_val,
  output logic [11:0]              dac_data,
  input  logic                     dac_complete,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               underrun_cnt,
  output logic                     late_err,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  // FIFO storage and bookkeeping
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic [AW:0]   level_next;
  logic          ready_reg;
  logic          wr_en;
  logic          pop;
  logic          empty;

  // Rate divider and tick bookkeeping
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;
  logic             pending_reg;
  logic             late_err_reg;
  logic             consume;

  // complete synchroniser
  logic sync1_reg;
  logic sync2_reg;
  logic complete_s;

  // Handshake FSM
  logic [1:0]  state_reg;
  logic        new_val_reg;
  logic [11:0] data_reg;
  logic [11:0] last_reg;
  logic [7:0]  underrun_reg;

  assign wr_en      = s_valid && ready_reg;
  assign empty      = (level_reg == '0);
  assign complete_s = sync2_reg;

  // A pending tick is taken only once the driver's complete has settled low.
  // sync1 is included so that, straight after reset (synchroniser cleared
  // while the driver may still hold complete high), no transfer can start
  // before the high level has propagated through to complete_s.
  assign consume = (state_reg == IDLE) && pending_reg && !complete_s && !sync1_reg;
  assign pop     = consume && !empty;

  // Divider compares with >= so a rate_div reduced below the running count
  // still produces the next tick promptly instead of wrapping the counter.
  assign tick = enable && (div_cnt_reg >= rate_div);

  // Sample memory write port (no reset so it can map onto block RAM)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  // Next occupancy: simultaneous write and pop leaves the level unchanged
  always_comb begin
    level_next = level_reg;
    case ({wr_en, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // FIFO pointers, level and registered ready (ready drops after the filling write)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      ready_reg  <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_next;
      ready_reg <= (level_next != FULL_LVL);
    end
  end

  // Rate divider: counts 0..rate_div, held at zero while disabled
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // Pending tick flag (ticks never queue) and sticky late-tick error
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg  <= 1'b0;
      late_err_reg <= 1'b0;
    end else begin
      if (!enable) begin
        pending_reg <= 1'b0;
      end else if (tick) begin
        pending_reg <= 1'b1;
      end else if (consume) begin
        pending_reg <= 1'b0;
      end
      if (tick && pending_reg) begin
        late_err_reg <= 1'b1;
      end
    end
  end

  // Two-flop synchroniser for the DAC driver's complete
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= dac_complete;
      sync2_reg <= sync1_reg;
    end
  end

  // Handshake FSM: IDLE -> ASSERT (hold new_val) -> RELEASE (wait complete low)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      new_val_reg  <= 1'b0;
      data_reg     <= 12'h800;
      last_reg     <= 12'h800;
      underrun_reg <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (consume) begin
            if (!empty) begin
              data_reg    <= mem[rd_ptr_reg];
              last_reg    <= mem[rd_ptr_reg];
              new_val_reg <= 1'b1;
              state_reg   <= ASSERT;
            end else begin
              if (underrun_reg != 8'hFF) begin
                underrun_reg <= underrun_reg + 1'b1;
              end
`ifdef DAC_FEEDER_HOLD_EN
              data_reg    <= last_reg;
              new_val_reg <= 1'b1;
              state_reg   <= ASSERT;
`endif
            end
          end
        end
        ASSERT: begin
          if (complete_s) begin
            new_val_reg <= 1'b0;
            state_reg   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!complete_s) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          new_val_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign s_ready      = ready_reg;
  assign dac_new_val  = new_val_reg;
  assign dac_data     = data_reg;
  assign fifo_level   = level_reg;
  assign underrun_cnt = underrun_reg;
  assign late_err     = late_err_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_dac_stream_feeder.sv
// Testbench for dac_stream_feeder: directed sequences plus a table-driven
// FIFO fill check. The DAC driver is modelled as a delayed echo of new_val.
module tb_dac_stream_feeder;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] rate_div = 16'd99;
  logic             s_valid = 1'b0;
  logic [11:0]      s_data = 12'h000;
  logic             s_ready;
  logic             dac_new_val;
  logic [11:0]      dac_data;
  logic             dac_complete;
  logic [LW-1:0]    fifo_level;
  logic [7:0]       underrun_cnt;
  logic             late_err;
  logic             busy;

  dac_stream_feeder #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rate_div     (rate_div),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .dac_new_val  (dac_new_val),
    .dac_data     (dac_data),
    .dac_complete (dac_complete),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt),
    .late_err     (late_err),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DAC driver model: complete is new_val delayed by comp_delay clocks,
  // or a forced level while force_en is set (history cleared meanwhile).
  logic [63:0] hist;
  int          comp_delay = 40;
  logic        force_en = 1'b1;
  logic        force_val = 1'b0;
  always @(posedge clk) hist <= force_en ? 64'd0 : {hist[62:0], dac_new_val};
  assign dac_complete = force_en ? force_val : hist[comp_delay-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transfer monitor: records each new_val rise and checks handshake phases
  logic [11:0] rise_q[$];
  int          rise_cyc[$];
  logic        prev_nv = 1'b0;
  logic [11:0] held = 12'h000;
  bit          unstable = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dac_new_val && !prev_nv) begin
          rise_q.push_back(dac_data);
          rise_cyc.push_back(cyc);
          held = dac_data;
          unstable = 1'b0;
          chk("complete_low_at_rise", 32'(dac_complete), 32'd0);
          chk("busy_at_rise", 32'(busy), 32'd1);
        end else if (dac_new_val && dac_data !== held) begin
          unstable = 1'b1;
        end
        if (!dac_new_val && prev_nv) begin
          chk("data_stable_while_new_val", 32'(unstable), 32'd0);
          chk("complete_high_at_fall", 32'(dac_complete), 32'd1);
        end
      end
      prev_nv = dac_new_val;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; force_en = 1'b1; force_val = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; force_en = 1'b0;
    rise_q.delete(); rise_cyc.delete();
  endtask

  task automatic push(input logic [11:0] d);
    @(negedge clk); s_valid = 1'b1; s_data = d;
    @(negedge clk); s_valid = 1'b0;
  endtask

  task automatic wait_rises(input int target, input int budget, input string name);
    int n = 0;
    while (rise_q.size() < target && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, 32'(rise_q.size() >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy || dac_new_val) && n < budget) begin
      @(negedge clk); n++;
    end
    chk(name, 32'(busy || dac_new_val), 32'd0);
  endtask

  typedef struct {
    logic [11:0] data;
    int          exp_level;
    logic        exp_ready;
  } vec_t;
  vec_t tbl[DEPTH+2];

  initial begin
    int base;
    // Fill table: DEPTH+2 back-to-back writes, last two must be dropped
    for (int i = 0; i < DEPTH + 2; i++) begin
      tbl[i].data      = 12'(32'h100 + i * 17);
      tbl[i].exp_level = (i + 1 < DEPTH) ? i + 1 : DEPTH;
      tbl[i].exp_ready = (i + 1 < DEPTH);
    end

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_new_val", 32'(dac_new_val), 32'd0);
    chk("rst_dac_data", 32'(dac_data), 32'h800);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_late_err", 32'(late_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Two samples at rate_div=99: order and 100-clock spacing
    rate_div = 16'd99;
    push(12'h123); push(12'h456);
    chk("t1_level_two", 32'(fifo_level), 32'd2);
    enable = 1'b1;
    wait_rises(2, 400, "t1_two_rises");
    enable = 1'b0;
    if (rise_q.size() >= 2) begin
      chk("t1_data0", 32'(rise_q[0]), 32'h123);
      chk("t1_data1", 32'(rise_q[1]), 32'h456);
      chk("t1_rise_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 32'd100);
    end
    wait_idle(300, "t1_idle");
    chk("t1_level_empty", 32'(fifo_level), 32'd0);
    chk("t1_no_underrun", 32'(underrun_cnt), 32'd0);
    chk("t1_no_late", 32'(late_err), 32'd0);

    // Table-driven fill with enable=0, then ordered drain
    rise_q.delete(); rise_cyc.delete();
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("fill_level", 32'(fifo_level), 32'(tbl[i-1].exp_level));
        chk("fill_ready", 32'(s_ready), 32'(tbl[i-1].exp_ready));
      end
      s_valid = 1'b1; s_data = tbl[i].data;
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("fill_level", 32'(fifo_level), 32'(tbl[DEPTH+1].exp_level));
    chk("fill_ready", 32'(s_ready), 32'(tbl[DEPTH+1].exp_ready));
    enable = 1'b1;
    wait_rises(DEPTH, DEPTH * 100 + 200, "drain_rises");
    enable = 1'b0;
    for (int i = 0; i < DEPTH && i < rise_q.size(); i++) begin
      chk("drain_order", 32'(rise_q[i]), 32'(tbl[i].data));
    end
    wait_idle(300, "drain_idle");
    chk("drain_level_empty", 32'(fifo_level), 32'd0);
    chk("drain_no_underrun", 32'(underrun_cnt), 32'd0);

    // Empty FIFO, three ticks
    do_reset();
    rate_div = 16'd99;
    enable = 1'b1;
    repeat (305) @(negedge clk);
    enable = 1'b0;
    wait_idle(300, "underrun_idle");
    chk("underrun_three", 32'(underrun_cnt), 32'd3);
`ifdef DAC_FEEDER_HOLD_EN
    chk("hold_transfers", 32'(rise_q.size()), 32'd3);
    for (int i = 0; i < rise_q.size(); i++) begin
      chk("hold_data", 32'(rise_q[i]), 32'h800);
    end
`else
    chk("no_hold_transfers", 32'(rise_q.size()), 32'd0);
`endif

    // Ticks faster than the handshake: late_err, transfers intact
    do_reset();
    rate_div = 16'd4;
    push(12'hA01); push(12'hA02); push(12'hA03);
    enable = 1'b1;
    wait_rises(3, 600, "late_rises");
    enable = 1'b0;
    wait_idle(300, "late_idle");
    chk("late_err_set", 32'(late_err), 32'd1);
    if (rise_q.size() >= 3) begin
      chk("late_data0", 32'(rise_q[0]), 32'hA01);
      chk("late_data1", 32'(rise_q[1]), 32'hA02);
      chk("late_data2", 32'(rise_q[2]), 32'hA03);
    end

    // Reset in the middle of a handshake, complete held high afterwards
    do_reset();
    rate_div = 16'd9;
    push(12'h5A5); push(12'h6B6);
    enable = 1'b1;
    wait_rises(1, 100, "rstmid_first_rise");
    chk("rstmid_new_val_high", 32'(dac_new_val), 32'd1);
    force_en = 1'b1; force_val = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_new_val_dropped", 32'(dac_new_val), 32'd0);
    chk("rstmid_fifo_discarded", 32'(fifo_level), 32'd0);
    force_val = 1'b1;
    rst = 1'b0;
    rate_div = 16'd0;
    base = rise_q.size();
    push(12'h777);
    repeat (10) @(negedge clk);
    chk("rstmid_no_rise_while_complete", 32'(rise_q.size()), 32'(base));
    force_val = 1'b0;
    wait_rises(base + 1, 20, "rstmid_rise_after_low");
    if (rise_q.size() > base) begin
      chk("rstmid_data", 32'(rise_q[base]), 32'h777);
    end
    enable = 1'b0;
    force_en = 1'b0;
    wait_idle(300, "rstmid_idle");

    // Underrun counter saturation
    do_reset();
    comp_delay = 2;
    rate_div = 16'd0;
    enable = 1'b1;
    repeat (5000) @(negedge clk);
    enable = 1'b0;
    wait_idle(100, "sat_idle");
    chk("underrun_saturated", 32'(underrun_cnt), 32'd255);
    comp_delay = 40;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dac_stream_feeder.md
# dac_stream_feeder

Sample-pacing stage placed directly upstream of the TLV5616 serial DAC driver. It buffers 12-bit samples from a producer (waveform generator or NCO) in a small FIFO. A programmable divider on clk_50 sets the sample rate. On each rate tick it hands one sample to the DAC driver over the level-held new_val/complete handshake, with the complete return synchronised from the DAC's slow serial clock domain.

## Interface
- DEPTH, 16, FIFO depth in samples; power of two, ≥ 4
- DIV_W, 16, width of rate divider
- clk  in  1  clk_50 system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  1 = generate rate ticks; 0 = divider held, no new transfers
- rate_div  in  DIV_W  tick period minus one, in clk cycles
- s_valid  in  1  producer sample valid
- s_data  in  12  producer sample, unsigned offset-binary
- s_ready  out  1  FIFO can accept (= !full)
- dac_new_val  out  1  to DAC driver new_val; held high until complete seen
- dac_data  out  12  to DAC driver data; stable while dac_new_val high
- dac_complete  in  1  from DAC driver complete (asynchronous to clk)
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- underrun_cnt  out  8  saturating count of ticks that found FIFO empty
- late_err  out  1  sticky: tick arrived while previous tick still pending
- busy  out  1  FSM not in IDLE

## Operation
- FIFO: write when s_valid && s_ready; pop only by FSM. Simultaneous write and pop with FIFO not empty → level unchanged. Write into an empty FIFO is not poppable in the same cycle (no bypass). Pointers wrap modulo DEPTH. fifo_level is 0..DEPTH.
- Divider: div_cnt counts 0..rate_div. tick=1 in the cycle div_cnt==rate_div, then div_cnt←0. rate_div=0 → tick every cycle. enable=0 → div_cnt←0, no tick, pending←0.
- pending flag: set by tick, cleared when FSM consumes it. A tick while pending is already 1 sets late_err (sticky until rst); pending stays 1, so ticks do not queue.
- complete_s: dac_complete through a 2-flop synchroniser.
- FSM states:
  - IDLE: if pending && !complete_s: if FIFO non-empty → pop, dac_data←head, dac_new_val←1, last←head, → ASSERT. If FIFO empty → underrun_cnt+1 (saturate at 255), then follow the Configuration section. Clear pending in both cases.
  - ASSERT: hold dac_new_val=1 and dac_data; when complete_s=1 → dac_new_val←0, → RELEASE.
  - RELEASE: when complete_s=0 → IDLE. This guarantees the driver saw new_val low before the next rising edge.
- enable dropped mid-transfer: the current ASSERT/RELEASE sequence completes normally.

## Timing
- Reset values: dac_new_val=0, dac_data=12'h800, last=12'h800, s_ready=1, fifo_level=0, underrun_cnt=0, late_err=0, busy=0, div_cnt=0, pending=0, synchroniser flops=0, state IDLE.
- Reset mid-handshake: dac_new_val drops the cycle after rst. FIFO contents are discarded. IDLE then waits for complete_s=0 before any new transfer.
- Latency: tick in cycle T → pending=1 in T+1 → dac_new_val=1 and dac_data valid from T+2 (FIFO non-empty, complete_s=0).
- complete rise → dac_new_val falls 3 clk later (2 sync + 1 FSM register).
- A full transfer takes roughly 16–17 DAC serial clocks plus sync delays. rate_div must exceed this, otherwise late_err flags it.
- s_ready is registered from full; it deasserts in the cycle after the write that fills the FIFO.

## Configuration
- DAC_FEEDER_HOLD_EN defined: an empty-FIFO tick re-sends `last` (zero-order hold). A full ASSERT/RELEASE handshake runs with dac_data=last.
- Not defined: an empty-FIFO tick produces no transfer. FSM stays in IDLE and dac_new_val stays 0.
- underrun_cnt increments in both builds.

## Test plan
- Reset, rate_div=99, write 0x123, 0x456. Model complete as a delayed echo of new_val (~40 clk). → dac_data 0x123 then 0x456; new_val rises 100 clk apart; each new_val rise is preceded by complete=0.
- Write DEPTH+2 samples back-to-back with enable=0. → s_ready=0 after DEPTH writes, fifo_level=DEPTH, extra samples dropped; enable=1 drains samples in order.
- Empty FIFO, enable=1, rate_div=99, 3 ticks. → underrun_cnt=3. With HOLD_EN: 3 transfers of 0x800. Without: new_val stays 0.
- rate_div=4 with slow complete (~40 clk). → late_err=1; transfers remain intact with no dropped handshake phases.
- Assert rst while new_val=1 and complete=0, then release rst with complete still high for 10 cycles. → new_val=0 the cycle after rst; no new_val rise until complete_s=0.
- 300 underrun ticks → underrun_cnt saturates at 255.
